// File: rtl/dtc_pkg.sv
// Shared definitions for the decision-tree classifier vote path: class geometry,
// accumulator FSM states and the index-to-one-hot helper.
package dtc_pkg;

  localparam int N_CLASSES = 10;
  localparam int CLASS_W   = 4;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    SCAN  = 2'd1,
    HOLD  = 2'd2
  } state_e;

  function automatic logic [N_CLASSES-1:0] class_onehot(input logic [CLASS_W-1:0] idx);
    logic [N_CLASSES-1:0] oh;
    oh = '0;
    for (int i = 0; i < N_CLASSES; i++) begin
      if (idx == CLASS_W'(i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

endpackage

// File: rtl/dtc_vote_counter.sv
// Per-class vote counter bank: parallel increment by the vote vector, synchronous
// clear, and a single read port addressed by the scan index.
module dtc_vote_counter
  import dtc_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 inc_i,
  input  logic [N_CLASSES-1:0] vec_i,
  input  logic                 clr_i,
  input  logic [CLASS_W-1:0]   rd_idx_i,
  output logic [CNT_W-1:0]     rd_cnt_o
);

  logic [CNT_W-1:0] cnt_q [N_CLASSES];
  logic [CNT_W-1:0] cnt_d [N_CLASSES];

  always_comb begin
    for (int i = 0; i < N_CLASSES; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr_i) begin
        cnt_d[i] = '0;
      end else if (inc_i && vec_i[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N_CLASSES; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_CLASSES; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Explicit decode keeps out-of-range scan indices reading as zero.
  always_comb begin
    rd_cnt_o = '0;
    for (int i = 0; i < N_CLASSES; i++) begin
      if (rd_idx_i == CLASS_W'(i)) rd_cnt_o = cnt_q[i];
    end
  end

endmodule

// File: rtl/dtc_vote_accum.sv
// Windowed vote accumulator behind the decision-tree classifier: counts votes per
// class, scans the bank one class per cycle, and presents the winner via valid/ready.
module dtc_vote_accum
  import dtc_pkg::*;
#(
  parameter int WINDOW = 8,
  parameter int CNT_W  = $clog2(WINDOW + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_CLASSES-1:0] in_vec,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CLASS_W-1:0]   out_class,
  output logic [CNT_W-1:0]     out_count,
  output logic [N_CLASSES-1:0] out_onehot,
  output logic                 out_none
);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     beat_q, beat_d;
  logic [CLASS_W-1:0]   scan_idx_q, scan_idx_d;
  logic [CLASS_W-1:0]   best_idx_q, best_idx_d;
  logic [CNT_W-1:0]     best_cnt_q, best_cnt_d;
  logic                 out_valid_q, out_valid_d;
  logic [CLASS_W-1:0]   out_class_q, out_class_d;
  logic [CNT_W-1:0]     out_count_q, out_count_d;
  logic [N_CLASSES-1:0] out_onehot_q, out_onehot_d;
  logic                 out_none_q, out_none_d;

  logic                 accept;
  logic                 close_win;
  logic                 handshake;
  logic [CNT_W-1:0]     rd_cnt;

  assign in_ready  = (state_q == ACCUM);
  assign accept    = in_valid && in_ready;
  assign close_win = accept && (in_last || (beat_q == CNT_W'(WINDOW - 1)));
  assign handshake = out_valid_q && out_ready;

  dtc_vote_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .inc_i    (accept),
    .vec_i    (in_vec),
    .clr_i    (handshake),
    .rd_idx_i (scan_idx_q),
    .rd_cnt_o (rd_cnt)
  );

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    scan_idx_d   = scan_idx_q;
    best_idx_d   = best_idx_q;
    best_cnt_d   = best_cnt_q;
    out_valid_d  = out_valid_q;
    out_class_d  = out_class_q;
    out_count_d  = out_count_q;
    out_onehot_d = out_onehot_q;
    out_none_d   = out_none_q;

    case (state_q)
      ACCUM: begin
        if (accept) begin
          beat_d = beat_q + CNT_W'(1);
          if (close_win) begin
            state_d    = SCAN;
            scan_idx_d = '0;
            best_idx_d = '0;
            best_cnt_d = '0;
          end
        end
      end
      SCAN: begin
        // Strictly-greater replacement leaves ties with the lowest index.
        if (rd_cnt > best_cnt_q) begin
          best_idx_d = scan_idx_q;
          best_cnt_d = rd_cnt;
        end
        if (scan_idx_q == CLASS_W'(N_CLASSES - 1)) begin
          state_d = HOLD;
        end else begin
          scan_idx_d = scan_idx_q + CLASS_W'(1);
        end
      end
      HOLD: begin
        // First HOLD cycle registers the result; it is then frozen until taken.
        if (!out_valid_q) begin
          out_valid_d  = 1'b1;
          out_none_d   = (best_cnt_q == '0);
          out_class_d  = best_idx_q;
          out_count_d  = best_cnt_q;
          out_onehot_d = (best_cnt_q == '0) ? '0 : class_onehot(best_idx_q);
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          beat_d      = '0;
          state_d     = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ACCUM;
      beat_q       <= '0;
      scan_idx_q   <= '0;
      best_idx_q   <= '0;
      best_cnt_q   <= '0;
      out_valid_q  <= 1'b0;
      out_class_q  <= '0;
      out_count_q  <= '0;
      out_onehot_q <= '0;
      out_none_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      scan_idx_q   <= scan_idx_d;
      best_idx_q   <= best_idx_d;
      best_cnt_q   <= best_cnt_d;
      out_valid_q  <= out_valid_d;
      out_class_q  <= out_class_d;
      out_count_q  <= out_count_d;
      out_onehot_q <= out_onehot_d;
      out_none_q   <= out_none_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_class  = out_class_q;
  assign out_count  = out_count_q;
  assign out_onehot = out_onehot_q;
  assign out_none   = out_none_q;

endmodule

// File: tb/tb_dtc_vote_accum.sv
// Bench for dtc_vote_accum: directed scenarios with literal expectations plus
// randomized traffic, all checked each cycle against a window-level vote model.
module tb_dtc_vote_accum;

  localparam int WIN = 8;
  localparam int NC  = 10;
  localparam int CW  = $clog2(WIN + 1);
  localparam int LAT = NC + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [NC-1:0] in_vec = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [3:0]    out_class;
  logic [CW-1:0] out_count;
  logic [NC-1:0] out_onehot;
  logic          out_none;

  always #5 clk = ~clk;

  dtc_vote_accum #(.WINDOW(WIN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_vec     (in_vec),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_class  (out_class),
    .out_count  (out_count),
    .out_onehot (out_onehot),
    .out_none   (out_none)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Window-level model: votes per class, beats seen, and a countdown to the result.
  bit            m_busy = 1'b0;
  int            m_wait = 0;
  int            m_beats = 0;
  int            m_cnt [NC];
  int            e_class = 0;
  int            e_count = 0;
  logic [NC-1:0] e_onehot = '0;
  bit            e_none = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  = 1'b0;
      m_wait  = 0;
      m_beats = 0;
      for (int c = 0; c < NC; c++) m_cnt[c] = 0;
    end else if (m_busy) begin
      if (m_wait == 0) begin
        if (out_ready) begin
          m_busy  = 1'b0;
          m_beats = 0;
          for (int c = 0; c < NC; c++) m_cnt[c] = 0;
        end
      end else begin
        m_wait--;
      end
    end else if (in_valid) begin
      for (int c = 0; c < NC; c++) if (in_vec[c]) m_cnt[c]++;
      m_beats++;
      if (m_beats == WIN || in_last) begin
        int mx;
        mx = 0;
        for (int c = 0; c < NC; c++) if (m_cnt[c] > mx) mx = m_cnt[c];
        e_count = mx;
        e_none  = (mx == 0);
        e_class = 0;
        if (mx > 0) begin
          for (int c = NC - 1; c >= 0; c--) if (m_cnt[c] == mx) e_class = c;
        end
        e_onehot = (mx > 0) ? (NC'(1) << e_class) : '0;
        m_busy = 1'b1;
        m_wait = LAT;
      end
    end
  end

  bit chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", in_ready, !m_busy);
      check("out_valid", out_valid, m_busy && (m_wait == 0));
      if (m_busy && m_wait == 0) begin
        check("out_class", out_class, e_class);
        check("out_count", out_count, e_count);
        check("out_onehot", out_onehot, e_onehot);
        check("out_none", out_none, e_none);
      end
    end
  end

  task automatic send(input logic [NC-1:0] v, input bit last);
    int g;
    g = 0;
    in_valid = 1'b1;
    in_vec   = v;
    in_last  = last;
    while (!in_ready && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 200) check("send_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_vec   = NC'($urandom);
  endtask

  task automatic send_n(input logic [NC-1:0] v, input int n, input bit last_on_final);
    for (int i = 0; i < n; i++) send(v, last_on_final && (i == n - 1));
  endtask

  task automatic wait_valid();
    int g;
    g = 0;
    while (!out_valid && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    check("valid_timeout", out_valid, 1);
  endtask

  task automatic expect_result(input int cls, input int cnt, input logic [NC-1:0] oh,
                               input bit none, input int acc_cyc);
    wait_valid();
    if (acc_cyc >= 0) check("latency", cyc - acc_cyc, LAT);
    check("res_class", out_class, cls);
    check("res_count", out_count, cnt);
    check("res_onehot", out_onehot, oh);
    check("res_none", out_none, none);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("in_ready_after_hs", in_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int acc;
    int seen;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #30;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_class", out_class, 0);
    check("rst_out_count", out_count, 0);
    check("rst_out_onehot", out_onehot, 0);
    check("rst_out_none", out_none, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #1;

    // Majority class with latency measurement.
    send_n(10'b0000001000, 5, 1'b0);
    send_n(10'b0000000001, 3, 1'b0);
    acc = cyc;
    expect_result(3, 5, 10'b0000001000, 1'b0, acc);

    // Tie goes to the lower index.
    send_n(10'b0000100000, 4, 1'b0);
    send_n(10'b0000000100, 4, 1'b0);
    expect_result(2, 4, 10'b0000000100, 1'b0, -1);

    // Early close with no votes; input stays blocked meanwhile.
    send_n(10'b0000000000, 3, 1'b1);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      check("early_in_ready", in_ready, 0);
    end
    expect_result(0, 0, 10'b0, 1'b1, -1);

    // Backpressure: result frozen while out_ready is low.
    send_n(10'b0000010000, 6, 1'b0);
    send_n(10'b1000000000, 2, 1'b0);
    wait_valid();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("bp_valid", out_valid, 1);
      check("bp_class", out_class, 4);
      check("bp_count", out_count, 6);
      check("bp_in_ready", in_ready, 0);
    end
    expect_result(4, 6, 10'b0000010000, 1'b0, -1);
    send_n(10'b0010000000, 8, 1'b0);
    expect_result(7, 8, 10'b0010000000, 1'b0, -1);

    // Multi-hot votes on every class.
    send_n(10'b1111111111, 8, 1'b0);
    expect_result(0, 8, 10'b0000000001, 1'b0, -1);

    // Single-vector window, and last coinciding with the full window.
    send(10'b0001000000, 1'b1);
    expect_result(6, 1, 10'b0001000000, 1'b0, -1);
    send_n(10'b0100000000, 8, 1'b1);
    expect_result(8, 8, 10'b0100000000, 1'b0, -1);

    // Reset during the 5th SCAN cycle discards the window.
    send_n(10'b0000000010, 8, 1'b0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_class", out_class, 0);
    check("midrst_out_count", out_count, 0);
    check("midrst_out_onehot", out_onehot, 0);
    check("midrst_out_none", out_none, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("midrst_no_valid", seen, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 2500; i++) begin
      int r;
      @(posedge clk); #1;
      r = $urandom_range(0, 7);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_vec    = (r == 0) ? '1 : (r == 1) ? '0 : NC'($urandom & $urandom & $urandom);
      in_last   = ($urandom_range(0, 9) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
